// File: rtl/biset_arbiter.sv
// biset_arbiter
//   Shares a single BiSet target port between N_REQ BiSet requesters.
//   Round-robin grant, one transaction in flight, registered outputs.
//   A watchdog answers on the target's behalf after TIMEOUT_CYC cycles
//   so a silent target can never hang a requester.
// Ports
//   clk, reset_n    rising-edge clock, async active-low reset
//   req_ctrl        N_REQ x {we,addr[7:0]}; slice i = [9*i+:9], !=0 means active
//   req_wdata       N_REQ x 32b write data;  slice i = [32*i+:32]
//   req_reply       N_REQ x {valid,data[31:0]}; slice i = [33*i+:33]
//   tgt_ctrl/wdata  request forwarded to the target
//   tgt_reply       {valid,data} from the target
//   busy            transaction in flight
//   grant_id        current / last granted requester
//   timeout_err     one-cycle pulse alongside a watchdog reply

// Per-requester reply register: loads on delivery, clears in RELEASE.
module biset_arbiter_lane (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load,
  input  logic        clr,
  input  logic [31:0] data,
  output logic [32:0] reply
);
  logic [32:0] reply_d, reply_q;

  always_comb begin
    reply_d = reply_q;
    if (load)     reply_d = {1'b1, data};
    else if (clr) reply_d = '0;
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) reply_q <= '0;
    else          reply_q <= reply_d;

  assign reply = reply_q;
endmodule

module biset_arbiter #(
  parameter  int          N_REQ        = 2,
  parameter  int          TIMEOUT_CYC  = 256,
  parameter  logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF,
  localparam int          GW           = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [N_REQ*9-1:0]    req_ctrl,
  input  logic [N_REQ*32-1:0]   req_wdata,
  output logic [N_REQ*33-1:0]   req_reply,
  output logic [8:0]            tgt_ctrl,
  output logic [31:0]           tgt_wdata,
  input  logic [32:0]           tgt_reply,
  output logic                  busy,
  output logic [GW-1:0]         grant_id,
  output logic                  timeout_err
);
  localparam int CW = $clog2(TIMEOUT_CYC);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RELEASE} state_t;

  state_t         state_d, state_q;
  logic [GW-1:0]  grant_id_d, grant_id_q;
  logic [GW-1:0]  rr_ptr_d, rr_ptr_q;
  logic [8:0]     tgt_ctrl_d, tgt_ctrl_q;
  logic [31:0]    tgt_wdata_d, tgt_wdata_q;
  logic [CW-1:0]  cnt_d, cnt_q;
  logic           timeout_err_d, timeout_err_q;

  logic [N_REQ-1:0][8:0]  ctrl_a;
  logic [N_REQ-1:0][31:0] wdata_a;
  logic [N_REQ-1:0][32:0] rep;
  logic [N_REQ-1:0]       req_act;

  logic           pick_vld;
  logic [GW-1:0]  pick_id;
  logic [GW:0]    scan;
  logic [GW:0]    rr_nxt;
  logic           deliver;
  logic [31:0]    deliver_data;
  logic           rel;

  assign rel = (state_q == S_RELEASE);

  for (genvar g = 0; g < N_REQ; g++) begin : g_lane
    assign ctrl_a[g]  = req_ctrl[9*g +: 9];
    assign wdata_a[g] = req_wdata[32*g +: 32];
    assign req_act[g] = |ctrl_a[g];

    biset_arbiter_lane u_lane (
      .clk     (clk),
      .reset_n (reset_n),
      .load    (deliver && (grant_id_q == GW'(g))),
      .clr     (rel),
      .data    (deliver_data),
      .reply   (rep[g])
    );

    assign req_reply[33*g +: 33] = rep[g];
  end

  // First active requester at or after rr_ptr, wrapping at N_REQ.
  always_comb begin
    pick_vld = 1'b0;
    pick_id  = '0;
    scan     = '0;
    for (int k = 0; k < N_REQ; k++) begin
      scan = {1'b0, rr_ptr_q} + (GW+1)'(k);
      if (scan >= (GW+1)'(N_REQ)) scan = scan - (GW+1)'(N_REQ);
      if (!pick_vld && req_act[scan[GW-1:0]]) begin
        pick_vld = 1'b1;
        pick_id  = scan[GW-1:0];
      end
    end
    rr_nxt = {1'b0, pick_id} + 1'b1;
    if (rr_nxt >= (GW+1)'(N_REQ)) rr_nxt = '0;
  end

  always_comb begin
    state_d       = state_q;
    grant_id_d    = grant_id_q;
    rr_ptr_d      = rr_ptr_q;
    tgt_ctrl_d    = tgt_ctrl_q;
    tgt_wdata_d   = tgt_wdata_q;
    cnt_d         = cnt_q;
    timeout_err_d = 1'b0;
    deliver       = 1'b0;
    deliver_data  = '0;
    case (state_q)
      S_IDLE: begin
        tgt_ctrl_d = '0;
        if (pick_vld) begin
          grant_id_d  = pick_id;
          tgt_ctrl_d  = ctrl_a[pick_id];
          tgt_wdata_d = wdata_a[pick_id];
          cnt_d       = '0;
          rr_ptr_d    = rr_nxt[GW-1:0];
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d = cnt_q + CW'(1);
        // A real reply takes priority over a watchdog expiring the same cycle.
        if (tgt_reply[32]) begin
          deliver      = 1'b1;
          deliver_data = tgt_reply[31:0];
          tgt_ctrl_d   = '0;
          state_d      = S_RELEASE;
        end else if (cnt_q == CW'(TIMEOUT_CYC-1)) begin
          deliver       = 1'b1;
          deliver_data  = TIMEOUT_DATA;
          timeout_err_d = 1'b1;
          tgt_ctrl_d    = '0;
          state_d       = S_RELEASE;
        end
      end
      S_RELEASE: begin
        // Dead cycle: lets the requester drop ctrl before we arbitrate again.
        tgt_ctrl_d = '0;
        state_d    = S_IDLE;
      end
      default: begin
        tgt_ctrl_d = '0;
        state_d    = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      grant_id_q    <= '0;
      rr_ptr_q      <= '0;
      tgt_ctrl_q    <= '0;
      tgt_wdata_q   <= '0;
      cnt_q         <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_id_q    <= grant_id_d;
      rr_ptr_q      <= rr_ptr_d;
      tgt_ctrl_q    <= tgt_ctrl_d;
      tgt_wdata_q   <= tgt_wdata_d;
      cnt_q         <= cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign tgt_ctrl    = tgt_ctrl_q;
  assign tgt_wdata   = tgt_wdata_q;
  assign grant_id    = grant_id_q;
  assign timeout_err = timeout_err_q;
  assign busy        = (state_q != S_IDLE);
endmodule
